// File: rtl/spram_arbiter_if.sv
// Requester and SPRAM-side bus of the SPRAM arbiter: loader, ROM and cart-RAM
// ports plus the SP256K control pins. The arbiter takes the slave side.
interface spram_arbiter_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned MW = 4;

  logic          load_done;
  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ack;
  logic          ld_err;

  logic          rom_req;
  logic [AW-1:0] rom_addr;
  logic          rom_ack;
  logic [DW-1:0] rom_rdata;
  logic          rom_valid;

  logic          ram_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [MW-1:0] ram_mask;
  logic          ram_ack;
  logic [DW-1:0] ram_rdata;
  logic          ram_valid;

  logic [AW-1:0] sp_ad;
  logic [DW-1:0] sp_di;
  logic [MW-1:0] sp_maskwe;
  logic          sp_we;
  logic          sp_cs;
  logic [DW-1:0] sp_do;

  modport slave (
    input  load_done, ld_req, ld_we, ld_addr, ld_wdata,
    input  rom_req, rom_addr,
    input  ram_req, ram_we, ram_addr, ram_wdata, ram_mask,
    input  sp_do,
    output ld_ack, ld_err,
    output rom_ack, rom_rdata, rom_valid,
    output ram_ack, ram_rdata, ram_valid,
    output sp_ad, sp_di, sp_maskwe, sp_we, sp_cs
  );

  modport master (
    output load_done, ld_req, ld_we, ld_addr, ld_wdata,
    output rom_req, rom_addr,
    output ram_req, ram_we, ram_addr, ram_wdata, ram_mask,
    output sp_do,
    input  ld_ack, ld_err,
    input  rom_ack, rom_rdata, rom_valid,
    input  ram_ack, ram_rdata, ram_valid,
    input  sp_ad, sp_di, sp_maskwe, sp_we, sp_cs
  );
endinterface

// File: rtl/spram_arbiter.sv
// Single-SPRAM arbiter: loader-only during boot, then ROM-over-RAM priority
// with a bounded-wait override so a pending RAM access is always served.
module spram_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic            clk_20M,
  input  logic            reset_n,
  spram_arbiter_if.slave  bus
);
  localparam int unsigned CW = 4;

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic v;
    logic is_ram;
  } tag_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  tag_t          tag0;
  tag_t          tag1;

  logic ld_win_c;
  logic rom_win_c;
  logic ram_win_c;
  logic ram_force_c;

  // Grant decision from the request levels present at this edge
  always_comb begin
    ld_win_c    = 1'b0;
    rom_win_c   = 1'b0;
    ram_win_c   = 1'b0;
    ram_force_c = bus.ram_req && (wait_cnt == CW'(MAX_WAIT));
    if (state == LOAD) begin
      ld_win_c = bus.ld_req && !bus.load_done;
    end else begin
      rom_win_c = bus.rom_req && !ram_force_c;
      ram_win_c = bus.ram_req && !rom_win_c;
    end
  end

  always_ff @(posedge clk_20M) begin
    if (!reset_n) begin
      state         <= LOAD;
      wait_cnt      <= '0;
      tag0          <= '0;
      tag1          <= '0;
      bus.ld_ack    <= 1'b0;
      bus.ld_err    <= 1'b0;
      bus.rom_ack   <= 1'b0;
      bus.rom_valid <= 1'b0;
      bus.rom_rdata <= '0;
      bus.ram_ack   <= 1'b0;
      bus.ram_valid <= 1'b0;
      bus.ram_rdata <= '0;
      bus.sp_cs     <= 1'b0;
      bus.sp_we     <= 1'b0;
      bus.sp_maskwe <= '0;
      bus.sp_ad     <= '0;
      bus.sp_di     <= '0;
    end else begin
      // Boot ends on the first load_done; only reset returns to LOAD
      if (state == LOAD && bus.load_done) state <= RUN;
      if (state == RUN && bus.ld_req) bus.ld_err <= 1'b1;

      if (state != RUN || ram_win_c || !bus.ram_req) begin
        wait_cnt <= '0;
      end else if (wait_cnt != CW'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + CW'(1);
      end

      bus.ld_ack  <= ld_win_c;
      bus.rom_ack <= rom_win_c;
      bus.ram_ack <= ram_win_c;
      bus.sp_cs   <= ld_win_c | rom_win_c | ram_win_c;

      // Command register; address and write data hold when idle
      if (ld_win_c) begin
        bus.sp_we     <= bus.ld_we;
        bus.sp_ad     <= bus.ld_addr;
        bus.sp_di     <= bus.ld_wdata;
        bus.sp_maskwe <= 4'hF;
      end else if (rom_win_c) begin
        bus.sp_we     <= 1'b0;
        bus.sp_ad     <= bus.rom_addr;
        bus.sp_maskwe <= '0;
      end else if (ram_win_c) begin
        bus.sp_we     <= bus.ram_we;
        bus.sp_ad     <= bus.ram_addr;
        bus.sp_di     <= bus.ram_wdata;
        bus.sp_maskwe <= bus.ram_mask;
      end else begin
        bus.sp_we     <= 1'b0;
        bus.sp_maskwe <= '0;
      end

      // Tag pipe lines up with sp_do, which is valid the cycle after the command
      tag0.v      <= rom_win_c | (ram_win_c & ~bus.ram_we);
      tag0.is_ram <= ram_win_c;
      tag1        <= tag0;

      bus.rom_valid <= tag1.v & ~tag1.is_ram;
      bus.ram_valid <= tag1.v &  tag1.is_ram;
      if (tag1.v && !tag1.is_ram) bus.rom_rdata <= bus.sp_do;
      if (tag1.v &&  tag1.is_ram) bus.ram_rdata <= bus.sp_do;
    end
  end
endmodule
